// File: rtl/sema_arbiter_pkg.sv
// Shared constants for the semaphore arbiter: FSM encoding, default offer timeout, counter width.
package sema_arbiter_pkg;

  localparam int CNT_W       = 8;
  localparam int DEF_TIMEOUT = 15;

  typedef logic [1:0] sema_state_t;

  localparam sema_state_t SEMA_EMPTY = 2'd0;
  localparam sema_state_t OFFER_WR   = 2'd1;
  localparam sema_state_t SEMA_FULL  = 2'd2;
  localparam sema_state_t OFFER_RD   = 2'd3;

endpackage

// File: rtl/sema_arbiter_if.sv
// CPU-port bundle for the semaphore arbiter; master drives requests/strobes, slave returns offers.
interface sema_arbiter_if
  import sema_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0] prod_req;
  logic [NUM_REQ-1:0] cons_req;
  logic [NUM_REQ-1:0] sema_write;
  logic [NUM_REQ-1:0] sema_data_in;
  logic [NUM_REQ-1:0] sema_ready;
  logic [NUM_REQ-1:0] sema_is_empty;
  logic [NUM_REQ-1:0] sema_valid;
  logic               sema_data_out;
  logic [CNT_W-1:0]   xfer_count;
  logic               timeout_pulse;

  modport master (
    output prod_req, cons_req, sema_write, sema_data_in, sema_ready,
    input  sema_is_empty, sema_valid, sema_data_out, xfer_count, timeout_pulse
  );

  modport slave (
    input  prod_req, cons_req, sema_write, sema_data_in, sema_ready,
    output sema_is_empty, sema_valid, sema_data_out, xfer_count, timeout_pulse
  );

endinterface

// File: rtl/sema_arbiter_rr_picker.sv
// Combinational round-robin selector: first request at or after i_ptr, wrapping.
// Zero latency; no backpressure (pure function of inputs).
module rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return PTR_W'(s);
  endfunction

  logic [PTR_W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < N; k++) begin
      w_j = f_wrap(i_ptr, k);
      if (!o_any && i_req[w_j]) begin
        o_any = 1'b1;
        o_idx = w_j;
      end
    end
    o_gnt[o_idx] = o_any;
  end

endmodule

// File: rtl/sema_arbiter.sv
// One-bit semaphore shared by NUM_REQ ports: round-robin write offer, then round-robin read offer.
// Grant and transfer each take 1 cycle; an unanswered offer is withdrawn after TIMEOUT cycles.
module sema_arbiter
  import sema_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  sema_arbiter_if.slave   bus
);

  localparam int               PTR_W   = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  sema_state_t        r_state;
  logic               r_slot;
  logic [PTR_W-1:0]   r_pptr;
  logic [PTR_W-1:0]   r_cptr;
  logic [PTR_W-1:0]   r_gidx;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_is_empty;
  logic [NUM_REQ-1:0] r_valid;
  logic               r_dout;
  logic [CNT_W-1:0]   r_xfer;
  logic               r_to_pulse;

  logic [NUM_REQ-1:0] w_pgnt;
  logic [PTR_W-1:0]   w_pidx;
  logic               w_pany;
  logic [NUM_REQ-1:0] w_cgnt;
  logic [PTR_W-1:0]   w_cidx;
  logic               w_cany;
  logic               w_timeout;

  rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_prod_pick (
    .i_req (bus.prod_req),
    .i_ptr (r_pptr),
    .o_gnt (w_pgnt),
    .o_idx (w_pidx),
    .o_any (w_pany)
  );

  rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_cons_pick (
    .i_req (bus.cons_req),
    .i_ptr (r_cptr),
    .o_gnt (w_cgnt),
    .o_idx (w_cidx),
    .o_any (w_cany)
  );

  // Strobe wins over timeout in the last offer cycle, so the check sits behind it.
  assign w_timeout = (r_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SEMA_EMPTY;
      r_slot     <= 1'b0;
      r_pptr     <= '0;
      r_cptr     <= '0;
      r_gidx     <= '0;
      r_cnt      <= '0;
      r_is_empty <= '0;
      r_valid    <= '0;
      r_dout     <= 1'b0;
      r_xfer     <= '0;
      r_to_pulse <= 1'b0;
    end else begin
      r_to_pulse <= 1'b0;
      case (r_state)
        SEMA_EMPTY: begin
          if (w_pany) begin
            r_state    <= OFFER_WR;
            r_gidx     <= w_pidx;
            r_pptr     <= f_inc(w_pidx);
            r_cnt      <= '0;
            r_is_empty <= w_pgnt;
          end
        end
        OFFER_WR: begin
          if (bus.sema_write[r_gidx]) begin
            r_slot     <= bus.sema_data_in[r_gidx];
            r_state    <= SEMA_FULL;
            r_is_empty <= '0;
          end else if (w_timeout) begin
            r_state    <= SEMA_EMPTY;
            r_is_empty <= '0;
            r_to_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SEMA_FULL: begin
          if (w_cany) begin
            r_state <= OFFER_RD;
            r_gidx  <= w_cidx;
            r_cptr  <= f_inc(w_cidx);
            r_cnt   <= '0;
            r_valid <= w_cgnt;
            r_dout  <= r_slot;
          end
        end
        OFFER_RD: begin
          if (bus.sema_ready[r_gidx]) begin
            r_xfer  <= r_xfer + 1'b1;
            r_state <= SEMA_EMPTY;
            r_valid <= '0;
            r_dout  <= 1'b0;
          end else if (w_timeout) begin
            r_state    <= SEMA_FULL;
            r_valid    <= '0;
            r_dout     <= 1'b0;
            r_to_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= SEMA_EMPTY;
      endcase
    end
  end

  assign bus.sema_is_empty = r_is_empty;
  assign bus.sema_valid    = r_valid;
  assign bus.sema_data_out = r_dout;
  assign bus.xfer_count    = r_xfer;
  assign bus.timeout_pulse = r_to_pulse;

endmodule
